ddr_rd_bw_engine: RTL and testbench

//  Parametrised DDR read-bandwidth engine; successor to the single-burst qt3_tpu_v1 read path.
//  - Issues N INCR read bursts from a base address on an AXI4 master port.
//  - Keeps up to MAX_OUTSTANDING bursts in flight.
//  - Sums all returned 32-bit words; counts elapsed cycles for bandwidth measurement.
//  - Flags response/protocol errors.
//  - Sits between the AXI-lite register file (start/base/count/results) and the DDR AXI port.

---
 rtl/ddr_rd_bw_engine_pkg.sv | 42 ++++
 rtl/ddr_rd_issue.sv | 83 ++++++++
 rtl/ddr_rd_bw_engine.sv | 210 +++++++++++++++++++++
 tb/tb_ddr_rd_bw_engine.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_rd_bw_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_bw_pkg
// Description : Shared types, AXI encodings and the per-beat lane adder for
//               the DDR read-bandwidth engine.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr_bw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;

    // Widest supported data bus and an adder width that cannot overflow
    // when summing sixteen 32-bit lanes.
    localparam int LANE_DATA_MAX = 512;
    localparam int LANE_SUM_W    = 64;

    // Sums the lowest 'lanes' 32-bit lanes of a zero-extended data beat.
    function automatic logic [LANE_SUM_W-1:0] lane_sum(
        input logic [LANE_DATA_MAX-1:0] data,
        input int                       lanes
    );
        logic [LANE_SUM_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < LANE_DATA_MAX / 32; i++) begin
            if (i < lanes) begin
                acc = acc + LANE_SUM_W'(data[i*32 +: 32]);
            end
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_rd_issue.sv
`default_nettype none
// ============================================================================
// Module      : ddr_rd_issue
// Description : AR-channel burst generator with an in-flight burst counter
//               that caps the number of outstanding read bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_rd_issue #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int NB_WIDTH        = 16,
    parameter int BURST_BYTES     = 64,
    parameter int OUT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 i_load,
    input  logic [31:0]          i_base_addr,
    input  logic                 i_run,
    input  logic [NB_WIDTH-1:0]  i_num_bursts,
    input  logic                 i_arready,
    input  logic                 i_r_last_hs,
    output logic                 o_arvalid,
    output logic [31:0]          o_araddr,
    output logic [NB_WIDTH-1:0]  o_issued,
    output logic [OUT_WIDTH-1:0] o_outstanding
);

    logic [NB_WIDTH-1:0]  r_issued;
    logic [OUT_WIDTH-1:0] r_outstanding;
    logic                 r_arvalid;
    logic [31:0]          r_araddr;

    logic                 w_ar_hs;
    logic [NB_WIDTH-1:0]  w_issued_next;
    logic [OUT_WIDTH-1:0] w_out_next;
    logic                 w_can_issue;

    assign w_ar_hs       = r_arvalid & i_arready;
    assign w_issued_next = r_issued + NB_WIDTH'(w_ar_hs);

    // Next in-flight count: a simultaneous AR accept and burst completion cancel out.
    always_comb begin
        w_out_next = r_outstanding;
        if (w_ar_hs && !i_r_last_hs) begin
            w_out_next = r_outstanding + 1'b1;
        end else if (!w_ar_hs && i_r_last_hs && (r_outstanding != '0)) begin
            w_out_next = r_outstanding - 1'b1;
        end
    end

    // Evaluated on next-cycle counts so a new request can follow a handshake immediately.
    assign w_can_issue = i_run && (w_issued_next < i_num_bursts)
                      && (w_out_next < OUT_WIDTH'(MAX_OUTSTANDING));

    // AR request register: held stable until accepted, address steps one burst per accept.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_issued      <= '0;
            r_outstanding <= '0;
            r_arvalid     <= 1'b0;
            r_araddr      <= '0;
        end else if (i_load) begin
            r_issued      <= '0;
            r_outstanding <= '0;
            r_arvalid     <= 1'b0;
            r_araddr      <= i_base_addr;
        end else begin
            r_issued      <= w_issued_next;
            r_outstanding <= w_out_next;
            r_arvalid     <= (r_arvalid && !i_arready) || w_can_issue;
            if (w_ar_hs) begin
                r_araddr <= r_araddr + 32'(BURST_BYTES);
            end
        end
    end

    assign o_arvalid     = r_arvalid;
    assign o_araddr      = r_araddr;
    assign o_issued      = r_issued;
    assign o_outstanding = r_outstanding;

endmodule
`default_nettype wire

// File: rtl/ddr_rd_bw_engine.sv
`default_nettype none
// ============================================================================
// Module      : ddr_rd_bw_engine
// Description : Issues N INCR read bursts with bounded outstanding requests,
//               sums every returned 32-bit word, counts run cycles and flags
//               response/burst-framing errors.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_rd_bw_engine
    import ddr_bw_pkg::*;
#(
    parameter int ID_WIDTH        = 1,
    parameter int DATA_WIDTH      = 64,
    parameter int B_BURST_LENGTH  = 8,
    parameter int BURST_LENGTH    = 7,
    parameter int MAX_OUTSTANDING = 4,
    parameter int NB_WIDTH        = 16,
    parameter int SUM_WIDTH       = 32,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      start,
    input  logic [31:0]               base_addr,
    input  logic [NB_WIDTH-1:0]       num_bursts,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [SUM_WIDTH-1:0]      sum,
    output logic [CNT_WIDTH-1:0]      cycle_count,
    output logic [ID_WIDTH-1:0]       m_axi_arid,
    output logic [31:0]               m_axi_araddr,
    output logic [B_BURST_LENGTH-1:0] m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arregion,
    output logic [3:0]                m_axi_arqos,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [ID_WIDTH-1:0]       m_axi_rid,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int c_lanes       = DATA_WIDTH / 32;
    localparam int c_burst_bytes = (BURST_LENGTH + 1) * (DATA_WIDTH / 8);
    localparam int c_out_width   = $clog2(MAX_OUTSTANDING + 1);

    state_t                    r_state;
    logic                      r_start_q;
    logic [NB_WIDTH-1:0]       r_num;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_error;
    logic [SUM_WIDTH-1:0]      r_sum;
    logic [CNT_WIDTH-1:0]      r_cycle_count;
    logic [B_BURST_LENGTH-1:0] r_beat;

    logic                      w_accept;
    logic                      w_r_hs;
    logic                      w_r_last_hs;
    logic                      w_beat_err;
    logic [NB_WIDTH-1:0]       w_issued;
    logic [c_out_width-1:0]    w_outstanding;
    logic [LANE_DATA_MAX-1:0]  w_rdata_ext;
    logic [LANE_SUM_W-1:0]     w_lane_total;
    logic [SUM_WIDTH-1:0]      w_beat_sum;
    logic                      w_unused;

    // Start is edge-triggered and only honoured between runs.
    assign w_accept    = start && !r_start_q && ((r_state == IDLE) || (r_state == DONE));
    assign w_r_hs      = m_axi_rvalid && r_busy;
    assign w_r_last_hs = w_r_hs && m_axi_rlast;
    assign w_unused    = ^m_axi_rid;

    ddr_rd_issue #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .NB_WIDTH        (NB_WIDTH),
        .BURST_BYTES     (c_burst_bytes),
        .OUT_WIDTH       (c_out_width)
    ) u_issue (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .i_load        (w_accept),
        .i_base_addr   (base_addr),
        .i_run         (r_state == RUN),
        .i_num_bursts  (r_num),
        .i_arready     (m_axi_arready),
        .i_r_last_hs   (w_r_last_hs),
        .o_arvalid     (m_axi_arvalid),
        .o_araddr      (m_axi_araddr),
        .o_issued      (w_issued),
        .o_outstanding (w_outstanding)
    );

    // Zero-extend the beat so the shared lane adder sees a fixed-width bus.
    always_comb begin
        w_rdata_ext                 = '0;
        w_rdata_ext[DATA_WIDTH-1:0] = m_axi_rdata;
    end

    assign w_lane_total = lane_sum(w_rdata_ext, c_lanes);
    assign w_beat_sum   = SUM_WIDTH'(w_lane_total);

    // rlast must land exactly on the final beat; a bad response is also an error.
    assign w_beat_err = (m_axi_rresp != AXI_RESP_OKAY)
                     || ( m_axi_rlast && (r_beat != B_BURST_LENGTH'(BURST_LENGTH)))
                     || (!m_axi_rlast && (r_beat == B_BURST_LENGTH'(BURST_LENGTH)));

    // Run-control FSM with registered busy/done.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= IDLE;
            r_start_q <= 1'b0;
            r_num     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_start_q <= start;
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_state <= RUN;
                        r_num   <= num_bursts;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_issued == r_num) begin
                        if (r_num == '0) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_outstanding == '0) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // R-channel accumulator, beat tracker and sticky error flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sum   <= '0;
            r_error <= 1'b0;
            r_beat  <= '0;
        end else if (w_accept) begin
            r_sum   <= '0;
            r_error <= 1'b0;
            r_beat  <= '0;
        end else if (w_r_hs) begin
            r_sum <= r_sum + w_beat_sum;
            if (w_beat_err) begin
                r_error <= 1'b1;
            end
            if (m_axi_rlast) begin
                r_beat <= '0;
            end else if (r_beat != B_BURST_LENGTH'(BURST_LENGTH)) begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    // Saturating run-time counter, live only while busy.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cycle_count <= '0;
        end else if (w_accept) begin
            r_cycle_count <= '0;
        end else if (r_busy && (r_cycle_count != '1)) begin
            r_cycle_count <= r_cycle_count + 1'b1;
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign sum            = r_sum;
    assign cycle_count    = r_cycle_count;
    assign m_axi_rready   = r_busy;

    assign m_axi_arid     = '0;
    assign m_axi_arlen    = B_BURST_LENGTH'(BURST_LENGTH);
    assign m_axi_arsize   = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_arburst  = AXI_BURST_INCR;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = AXI_CACHE_DEF;
    assign m_axi_arprot   = '0;
    assign m_axi_arregion = '0;
    assign m_axi_arqos    = '0;

endmodule
`default_nettype wire

// File: tb/tb_ddr_rd_bw_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_rd_bw_engine
// Description : Directed self-checking bench for ddr_rd_bw_engine with a
//               behavioural AXI read slave (memory word[i] = i from base).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_rd_bw_engine;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] num_bursts = '0;
    logic        busy, done, error;
    logic [31:0] sum, cycle_count;
    logic [0:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arregion, m_axi_arqos;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [0:0]  m_axi_rid = '0;
    logic [63:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    int n_vec = 0;
    int n_err = 0;

    // Slave model state
    logic [31:0] ar_q[$];
    logic [31:0] cur_base = '0, cur_addr = '0, last_araddr = '0, prev_araddr = '0;
    int ar_count = 0, r_beats_total = 0, out_model = 0, out_max = 0;
    int addr_errs = 0, stab_errs = 0, arvalid_seen = 0;
    int gap_min = 0, gap_max = 0, gap = 0;
    int err_burst = -1, err_beat = 0, early_burst = -1, early_beat = 0;
    int burst_idx = 0, cur_beat = 0;
    bit ar_rand = 1'b0, cur_active = 1'b0, r_hs_pend = 1'b0, prev_ar_stall = 1'b0;

    ddr_rd_bw_engine dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .base_addr(base_addr),
        .num_bursts(num_bursts), .busy(busy), .done(done), .error(error), .sum(sum),
        .cycle_count(cycle_count), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arregion(m_axi_arregion), .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    always #5 aclk = ~aclk;

    function automatic int pick_gap();
        return gap_min + int'($urandom_range(0, gap_max - gap_min));
    endfunction

    // AXI read slave: all decisions at the falling edge, handshakes happen at the next rising edge.
    initial begin
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                ar_q.delete();
                cur_active = 1'b0; r_hs_pend = 1'b0; prev_ar_stall = 1'b0;
                m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_arready = 1'b0;
                out_model = 0;
            end else begin
                if (prev_ar_stall && (!m_axi_arvalid || (m_axi_araddr != prev_araddr))) stab_errs++;
                if (r_hs_pend) begin
                    r_hs_pend = 1'b0;
                    r_beats_total++;
                    if (m_axi_rlast) begin
                        cur_active = 1'b0; out_model--; burst_idx++;
                    end else begin
                        cur_beat++;
                    end
                    m_axi_rvalid = 1'b0;
                    gap = pick_gap();
                end
                if (!m_axi_rvalid) begin
                    if (!cur_active && (ar_q.size() > 0)) begin
                        cur_addr = ar_q.pop_front(); cur_active = 1'b1; cur_beat = 0;
                    end
                    if (cur_active) begin
                        if (gap > 0) begin
                            gap--;
                        end else begin
                            int k;
                            k = int'((cur_addr - cur_base) / 8) + cur_beat;
                            m_axi_rdata  = {32'(2*k + 1), 32'(2*k)};
                            m_axi_rlast  = (burst_idx == early_burst) ? (cur_beat == early_beat) : (cur_beat == 7);
                            m_axi_rresp  = ((burst_idx == err_burst) && (cur_beat == err_beat)) ? 2'b10 : 2'b00;
                            m_axi_rvalid = 1'b1;
                        end
                    end
                end
                m_axi_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                if (m_axi_arvalid) arvalid_seen++;
                if (m_axi_arvalid && m_axi_arready) begin
                    if (m_axi_araddr != cur_base + 32'(ar_count * 64)) addr_errs++;
                    ar_q.push_back(m_axi_araddr);
                    last_araddr = m_axi_araddr;
                    ar_count++; out_model++;
                    if (out_model > out_max) out_max = out_model;
                end
                prev_ar_stall = m_axi_arvalid && !m_axi_arready;
                prev_araddr   = m_axi_araddr;
                r_hs_pend     = m_axi_rvalid && m_axi_rready;
            end
        end
    end

    task automatic start_run(input logic [31:0] b, input logic [15:0] n);
        @(negedge aclk);
        ar_count = 0; r_beats_total = 0; out_max = 0; addr_errs = 0; stab_errs = 0;
        arvalid_seen = 0; burst_idx = 0; cur_base = b;
        base_addr = b; num_bursts = n; start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge aclk);
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset.busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset.done: got %b want 0", done); end
        n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL reset.error: got %b want 0", error); end
        n_vec++; if (sum !== 32'd0) begin n_err++; $display("FAIL reset.sum: got %0d want 0", sum); end
        n_vec++; if (cycle_count !== 32'd0) begin n_err++; $display("FAIL reset.cycles: got %0d want 0", cycle_count); end
        n_vec++; if (m_axi_arvalid !== 1'b0) begin n_err++; $display("FAIL reset.arvalid: got %b want 0", m_axi_arvalid); end
        n_vec++; if (m_axi_rready !== 1'b0) begin n_err++; $display("FAIL reset.rready: got %b want 0", m_axi_rready); end
        n_vec++; if (m_axi_arlen !== 8'd7) begin n_err++; $display("FAIL static.arlen: got %0d want 7", m_axi_arlen); end
        n_vec++; if (m_axi_arsize !== 3'd3) begin n_err++; $display("FAIL static.arsize: got %0d want 3", m_axi_arsize); end
        n_vec++; if (m_axi_arburst !== 2'b01) begin n_err++; $display("FAIL static.arburst: got %b want 01", m_axi_arburst); end
        n_vec++; if (m_axi_arcache !== 4'b0011) begin n_err++; $display("FAIL static.arcache: got %b want 0011", m_axi_arcache); end
        n_vec++; if ({m_axi_arid, m_axi_arlock, m_axi_arprot, m_axi_arregion, m_axi_arqos} !== 13'd0) begin
            n_err++; $display("FAIL static.zero_fields: got %h want 0", {m_axi_arid, m_axi_arlock, m_axi_arprot, m_axi_arregion, m_axi_arqos}); end
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_single_burst();
        bit ok;
        gap_min = 10; gap_max = 20; ar_rand = 1'b0;
        start_run(32'h4000_0000, 16'd1);
        wait_done(2000, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL single.timeout: done=%b want 1", done); end
        n_vec++; if (sum !== 32'd120) begin n_err++; $display("FAIL single.sum: got %0d want 120", sum); end
        n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL single.error: got %b want 0", error); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single.busy: got %b want 0", busy); end
        n_vec++; if (ar_count !== 1) begin n_err++; $display("FAIL single.ar_count: got %0d want 1", ar_count); end
        n_vec++; if (last_araddr !== 32'h4000_0000) begin n_err++; $display("FAIL single.araddr: got %h want 40000000", last_araddr); end
    endtask

    task automatic test_outstanding();
        bit ok;
        gap_min = 0; gap_max = 0; ar_rand = 1'b0;
        start_run(32'h4000_0000, 16'd32);
        wait_done(5000, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL multi.timeout: done=%b want 1", done); end
        n_vec++; if (sum !== 32'd130816) begin n_err++; $display("FAIL multi.sum: got %0d want 130816", sum); end
        n_vec++; if (ar_count !== 32) begin n_err++; $display("FAIL multi.ar_count: got %0d want 32", ar_count); end
        n_vec++; if (last_araddr !== 32'h4000_07C0) begin n_err++; $display("FAIL multi.last_araddr: got %h want 400007c0", last_araddr); end
        n_vec++; if (addr_errs !== 0) begin n_err++; $display("FAIL multi.addr_seq: got %0d bad addresses want 0", addr_errs); end
        n_vec++; if (out_max > 4) begin n_err++; $display("FAIL multi.outstanding: got max %0d want <=4", out_max); end
        n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL multi.error: got %b want 0", error); end
    endtask

    task automatic test_zero_bursts();
        start_run(32'h4000_0000, 16'd0);
        n_vec++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL zero.first_cycle: busy,done=%b%b want 10", busy, done); end
        @(negedge aclk);
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL zero.done: got %b want 1", done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero.busy: got %b want 0", busy); end
        n_vec++; if (cycle_count !== 32'd1) begin n_err++; $display("FAIL zero.cycles: got %0d want 1", cycle_count); end
        n_vec++; if (sum !== 32'd0) begin n_err++; $display("FAIL zero.sum: got %0d want 0", sum); end
        repeat (3) @(negedge aclk);
        n_vec++; if (arvalid_seen !== 0) begin n_err++; $display("FAIL zero.arvalid: seen %0d cycles want 0", arvalid_seen); end
        n_vec++; if (cycle_count !== 32'd1) begin n_err++; $display("FAIL zero.cycles_frozen: got %0d want 1", cycle_count); end
    endtask

    task automatic test_slverr();
        bit ok;
        gap_min = 1; gap_max = 3; ar_rand = 1'b1; err_burst = 2; err_beat = 3;
        start_run(32'h4000_0000, 16'd4);
        repeat (8) @(negedge aclk);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        wait_done(3000, ok);
        err_burst = -1; ar_rand = 1'b0;
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL slverr.timeout: done=%b want 1", done); end
        n_vec++; if (error !== 1'b1) begin n_err++; $display("FAIL slverr.error: got %b want 1", error); end
        n_vec++; if (sum !== 32'd2016) begin n_err++; $display("FAIL slverr.sum: got %0d want 2016", sum); end
        n_vec++; if (ar_count !== 4) begin n_err++; $display("FAIL slverr.ar_count: got %0d want 4", ar_count); end
        n_vec++; if (stab_errs !== 0) begin n_err++; $display("FAIL slverr.ar_stable: got %0d violations want 0", stab_errs); end
        n_vec++; if (addr_errs !== 0) begin n_err++; $display("FAIL slverr.addr_seq: got %0d bad addresses want 0", addr_errs); end
    endtask

    task automatic test_early_rlast();
        bit ok;
        gap_min = 2; gap_max = 4; early_burst = 0; early_beat = 5;
        start_run(32'h4000_0000, 16'd1);
        wait_done(1000, ok);
        early_burst = -1;
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL early.timeout: done=%b want 1", done); end
        n_vec++; if (error !== 1'b1) begin n_err++; $display("FAIL early.error: got %b want 1", error); end
        n_vec++; if (sum !== 32'd66) begin n_err++; $display("FAIL early.sum: got %0d want 66", sum); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL early.busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        gap_min = 0; gap_max = 2;
        start_run(32'h4000_1000, 16'd2);
        wait_done(1000, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b.timeout: done=%b want 1", done); end
        n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL b2b.error_cleared: got %b want 0", error); end
        n_vec++; if (sum !== 32'd496) begin n_err++; $display("FAIL b2b.sum: got %0d want 496", sum); end
        n_vec++; if (last_araddr !== 32'h4000_1040) begin n_err++; $display("FAIL b2b.last_araddr: got %h want 40001040", last_araddr); end
    endtask

    task automatic test_reset_mid_drain();
        bit ok;
        gap_min = 10; gap_max = 20; ok = 1'b0;
        start_run(32'h4000_0000, 16'd4);
        for (int i = 0; i < 2000; i++) begin
            @(negedge aclk);
            if ((ar_count == 4) && (r_beats_total >= 3)) begin ok = 1'b1; break; end
        end
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL rstmid.reach_drain: reached=%b want 1", ok); end
        n_vec++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL rstmid.pre_state: busy,done=%b%b want 10", busy, done); end
        #2 aresetn = 1'b0;
        #1;
        n_vec++; if ({busy, done, error} !== 3'b000) begin n_err++; $display("FAIL rstmid.flags: busy,done,error=%b%b%b want 000", busy, done, error); end
        n_vec++; if (sum !== 32'd0) begin n_err++; $display("FAIL rstmid.sum: got %0d want 0", sum); end
        n_vec++; if ({m_axi_arvalid, m_axi_rready} !== 2'b00) begin n_err++; $display("FAIL rstmid.axi: arvalid,rready=%b%b want 00", m_axi_arvalid, m_axi_rready); end
        n_vec++; if (cycle_count !== 32'd0) begin n_err++; $display("FAIL rstmid.cycles: got %0d want 0", cycle_count); end
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        start_run(32'h4000_0000, 16'd1);
        wait_done(2000, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL rstmid.rerun_timeout: done=%b want 1", done); end
        n_vec++; if (sum !== 32'd120) begin n_err++; $display("FAIL rstmid.rerun_sum: got %0d want 120", sum); end
        n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL rstmid.rerun_error: got %b want 0", error); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_outstanding();
        test_zero_bursts();
        test_slverr();
        test_early_rlast();
        test_back_to_back();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
